// File: rtl/recorder_pkg.sv
// Shared types and default sizing for the recorder controller slice.
package recorder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY
  } recState_t;

  typedef enum logic [1:0] {
    LEN_NOP,
    LEN_WRITE,
    LEN_CLEAR,
    LEN_CLEAR_ALL
  } lenOp_t;

  localparam int DEFAULT_NUM_CLIPS  = 4;
  localparam int DEFAULT_CLIP_DEPTH = 8192;
  localparam int DEFAULT_CLIP_W     = $clog2(DEFAULT_NUM_CLIPS);
  localparam int DEFAULT_OFFSET_W   = $clog2(DEFAULT_CLIP_DEPTH);
  localparam int DEFAULT_LENGTH_W   = DEFAULT_OFFSET_W + 1;
  localparam int DEFAULT_ADDR_W     = DEFAULT_CLIP_W + DEFAULT_OFFSET_W;

endpackage

// File: rtl/clip_length_table.sv
// Per-clip recorded-length registers with a write/clear-one/clear-all port and one read port.
module clip_length_table
  import recorder_pkg::*;
#(
  parameter int  NUM_CLIPS  = DEFAULT_NUM_CLIPS,
  parameter int  CLIP_DEPTH = DEFAULT_CLIP_DEPTH,
  localparam int CLIP_W     = $clog2(NUM_CLIPS),
  localparam int LEN_W      = $clog2(CLIP_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  lenOp_t            lenOp,
  input  logic [CLIP_W-1:0] wrIdx,
  input  logic [LEN_W-1:0]  wrData,
  input  logic [CLIP_W-1:0] rdIdx,
  output logic [LEN_W-1:0]  rdLength
);

  logic [LEN_W-1:0] lengths [NUM_CLIPS];

  // NOTE: this small table is reset like ordinary state because an empty clip must read as length 0 after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLIPS; i++) lengths[i] <= '0;
    end else begin
      case (lenOp)
        LEN_WRITE:     lengths[wrIdx] <= wrData;
        LEN_CLEAR:     lengths[wrIdx] <= '0;
        LEN_CLEAR_ALL: for (int i = 0; i < NUM_CLIPS; i++) lengths[i] <= '0;
        default:       ;
      endcase
    end
  end

  assign rdLength = lengths[rdIdx];

endmodule

// File: rtl/recorder_controller.sv
// Recorder controller: IDLE/RECORD/PLAY sequencer issuing clip-addressed sample memory strobes.
// Define RECORDER_CTRL_LOOP_EN to make playback loop until stopped; otherwise playback is single-shot.
module recorder_controller
  import recorder_pkg::*;
#(
  parameter int  NUM_CLIPS  = DEFAULT_NUM_CLIPS,
  parameter int  CLIP_DEPTH = DEFAULT_CLIP_DEPTH,
  localparam int CLIP_W     = $clog2(NUM_CLIPS),
  localparam int OFF_W      = $clog2(CLIP_DEPTH),
  localparam int LEN_W      = OFF_W + 1,
  localparam int ADDR_W     = CLIP_W + OFF_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              PlaySync,
  input  logic              RecordSync,
  input  logic              ClipNumPlaySync,
  input  logic              ClipNumRecordSync,
  input  logic              resetButtonSync,
  input  logic              sampleTick,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic              memRe,
  output logic [CLIP_W-1:0] playClip,
  output logic [CLIP_W-1:0] recordClip,
  output logic              recording,
  output logic              playing,
  output logic              clipFull
);

  recState_t        state;
  logic [OFF_W-1:0] offset;
  logic             lastStrobe;
  lenOp_t           lenOp;
  logic [LEN_W-1:0] playLength;
  logic [LEN_W-1:0] nextLength;
  logic             recWrite;
  logic             playRead;
  logic             playLast;

  // The final strobe of an operation keeps the FSM busy for one cycle so strobes never coincide with IDLE.
  assign nextLength = {1'b0, offset} + LEN_W'(1);
  assign recWrite   = (state == RECORD) && sampleTick && !RecordSync && !lastStrobe && !resetButtonSync;
  assign playRead   = (state == PLAY) && sampleTick && !PlaySync && !lastStrobe && !resetButtonSync;
  assign playLast   = (nextLength == playLength);

  always_comb begin
    lenOp = LEN_NOP;
    if (resetButtonSync)                      lenOp = LEN_CLEAR_ALL;
    else if ((state == IDLE) && RecordSync)   lenOp = LEN_CLEAR;
    else if (recWrite)                        lenOp = LEN_WRITE;
  end

  clip_length_table #(
    .NUM_CLIPS (NUM_CLIPS),
    .CLIP_DEPTH(CLIP_DEPTH)
  ) u_lengths (
    .clock   (clock),
    .reset   (reset),
    .lenOp   (lenOp),
    .wrIdx   (recordClip),
    .wrData  (nextLength),
    .rdIdx   (playClip),
    .rdLength(playLength)
  );

  // NOTE: every output here is a register updated with non-blocking assignments, so consumers see glitch-free strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      offset     <= '0;
      lastStrobe <= 1'b0;
      memAddr    <= '0;
      memWe      <= 1'b0;
      memRe      <= 1'b0;
      playClip   <= '0;
      recordClip <= '0;
      recording  <= 1'b0;
      playing    <= 1'b0;
      clipFull   <= 1'b0;
    end else begin
      memWe    <= 1'b0;
      memRe    <= 1'b0;
      clipFull <= 1'b0;
      if (resetButtonSync) begin
        state      <= IDLE;
        recording  <= 1'b0;
        playing    <= 1'b0;
        offset     <= '0;
        lastStrobe <= 1'b0;
        playClip   <= '0;
        recordClip <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (RecordSync) begin
              state      <= RECORD;
              recording  <= 1'b1;
              offset     <= '0;
              lastStrobe <= 1'b0;
            end else if (PlaySync && (playLength != '0)) begin
              state      <= PLAY;
              playing    <= 1'b1;
              offset     <= '0;
              lastStrobe <= 1'b0;
            end else begin
              if (ClipNumPlaySync)   playClip   <= playClip + CLIP_W'(1);
              if (ClipNumRecordSync) recordClip <= recordClip + CLIP_W'(1);
            end
          end
          RECORD: begin
            if (lastStrobe || RecordSync) begin
              state     <= IDLE;
              recording <= 1'b0;
              clipFull  <= lastStrobe;
            end else if (recWrite) begin
              memWe      <= 1'b1;
              memAddr    <= {recordClip, offset};
              offset     <= offset + OFF_W'(1);
              lastStrobe <= &offset;
            end
          end
          PLAY: begin
            if (lastStrobe || PlaySync) begin
              state   <= IDLE;
              playing <= 1'b0;
            end else if (playRead) begin
              memRe   <= 1'b1;
              memAddr <= {playClip, offset};
`ifdef RECORDER_CTRL_LOOP_EN
              offset  <= playLast ? '0 : offset + OFF_W'(1);
`else
              offset     <= offset + OFF_W'(1);
              lastStrobe <= playLast;
`endif
            end
          end
          default: begin
            state     <= IDLE;
            recording <= 1'b0;
            playing   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_recorder_controller.sv
// Scoreboard bench for recorder_controller: a clip-level reference model predicts memory strobes.
module tb_recorder_controller;

  localparam int NUM_CLIPS  = 4;
  localparam int CLIP_DEPTH = 16;
  localparam int CLIP_W     = 2;
  localparam int ADDR_W     = 6;
`ifdef RECORDER_CTRL_LOOP_EN
  localparam bit LOOP_MODE = 1'b1;
`else
  localparam bit LOOP_MODE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic PlaySync = 1'b0, RecordSync = 1'b0, ClipNumPlaySync = 1'b0;
  logic ClipNumRecordSync = 1'b0, resetButtonSync = 1'b0, sampleTick = 1'b0;
  logic [ADDR_W-1:0] memAddr;
  logic memWe, memRe, recording, playing, clipFull;
  logic [CLIP_W-1:0] playClip, recordClip;

  always #5 clock = ~clock;

  recorder_controller #(.NUM_CLIPS(NUM_CLIPS), .CLIP_DEPTH(CLIP_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .PlaySync(PlaySync), .RecordSync(RecordSync),
    .ClipNumPlaySync(ClipNumPlaySync), .ClipNumRecordSync(ClipNumRecordSync),
    .resetButtonSync(resetButtonSync), .sampleTick(sampleTick),
    .memAddr(memAddr), .memWe(memWe), .memRe(memRe),
    .playClip(playClip), .recordClip(recordClip),
    .recording(recording), .playing(playing), .clipFull(clipFull)
  );

  typedef struct {bit isWrite; int addr;} memOp_t;
  memOp_t expQ[$];

  int passed = 0, total = 0;
  int clipFullSeen = 0, clipFullExp = 0;
  int lens[NUM_CLIPS];
  int playSel = 0, recSel = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic bit coin();
    return $urandom_range(0, 3) == 0;
  endfunction

  // Monitor: every strobe the DUT presents must match the head of the expectation queue.
  always @(negedge clock) begin
    memOp_t e;
    if (clipFull) clipFullSeen++;
    if (memWe || memRe) begin
      check("single strobe", int'(memWe && memRe), 0);
      check("strobe while busy", int'(memWe ? recording : playing), 1);
      if (expQ.size() == 0) begin
        total++;
        $display("FAIL unexpected strobe: we=%0d re=%0d addr=%0d, none expected (t=%0t)",
                 memWe, memRe, memAddr, $time);
      end else begin
        e = expQ.pop_front();
        check("strobe kind (1=write)", int'(memWe), int'(e.isWrite));
        check("strobe address", int'(memAddr), e.addr);
      end
    end
  end

  task automatic step(input bit p, input bit r, input bit cp, input bit cr, input bit rb, input bit t);
    PlaySync = p; RecordSync = r; ClipNumPlaySync = cp;
    ClipNumRecordSync = cr; resetButtonSync = rb; sampleTick = t;
    @(posedge clock); #1;
    PlaySync = 0; RecordSync = 0; ClipNumPlaySync = 0;
    ClipNumRecordSync = 0; resetButtonSync = 0; sampleTick = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clearModel();
    foreach (lens[i]) lens[i] = 0;
    playSel = 0;
    recSel  = 0;
  endtask

  task automatic checkSelections();
    check("playClip", int'(playClip), playSel);
    check("recordClip", int'(recordClip), recSel);
  endtask

  task automatic doRecord(input int n);
    int clip = recSel;
    step(0, 1, 0, 0, 0, 0);
    lens[clip] = 0;
    check("recording after RecordSync", int'(recording), 1);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      expQ.push_back('{1'b1, clip * CLIP_DEPTH + i});
      step(coin(), 0, coin(), coin(), 0, 1);
    end
    lens[clip] = n;
    if (n == CLIP_DEPTH) clipFullExp++;
    else step(0, 1, 0, 0, 0, 0);
    idle(3);
    check("recording after record", int'(recording), 0);
    check("clipFull pulses", clipFullSeen, clipFullExp);
  endtask

  task automatic doPlay(input int n);
    int clip = playSel;
    int len  = lens[clip];
    bit active;
    step(1, 0, 0, 0, 0, 0);
    check("playing after PlaySync", int'(playing), int'(len != 0));
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      active = (len != 0) && (LOOP_MODE || i < len);
      if (active) expQ.push_back('{1'b0, clip * CLIP_DEPTH + (i % (len == 0 ? 1 : len))});
      step(0, active && coin(), active && coin(), active && coin(), 0, 1);
      if (!LOOP_MODE && len != 0 && i == len - 1) begin
        idle(1);
        check("playing after last read", int'(playing), 0);
      end
    end
    if (len != 0 && (LOOP_MODE || n < len)) step(1, 0, 0, 0, 0, 0);
    idle(3);
    check("playing after play", int'(playing), 0);
  endtask

  task automatic doSelect(input int k);
    bit cp, cr;
    for (int j = 0; j < k; j++) begin
      cp = $urandom_range(0, 1) == 1;
      cr = $urandom_range(0, 1) == 1;
      step(0, 0, cp, cr, 0, 0);
      if (cp) playSel = (playSel + 1) % NUM_CLIPS;
      if (cr) recSel  = (recSel + 1) % NUM_CLIPS;
    end
    checkSelections();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    clearModel();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check("reset memAddr", int'(memAddr), 0);
    check("reset memWe", int'(memWe), 0);
    check("reset memRe", int'(memRe), 0);
    check("reset recording", int'(recording), 0);
    check("reset playing", int'(playing), 0);
    check("reset clipFull", int'(clipFull), 0);
    checkSelections();

    // Record 5 samples into clip 0, then play it back with one surplus tick.
    doRecord(5);
    doPlay(6);

    // Five record-select pulses wrap to clip 1; fill it completely.
    repeat (5) step(0, 0, 0, 1, 0, 0);
    recSel = (recSel + 5) % NUM_CLIPS;
    checkSelections();
    doRecord(CLIP_DEPTH);

    // Simultaneous PlaySync and RecordSync: record wins and empties clip 1.
    step(1, 1, 0, 0, 0, 0);
    lens[recSel] = 0;
    check("record wins: recording", int'(recording), 1);
    check("record wins: playing", int'(playing), 0);
    step(0, 1, 0, 0, 0, 0);
    idle(2);
    check("recording after empty record", int'(recording), 0);

    // Play on the now-empty clip 1 is ignored.
    step(0, 0, 1, 0, 0, 0);
    playSel = 1;
    doPlay(3);

    // Reset button during play of clip 0 at offset 3.
    repeat (3) step(0, 0, 1, 0, 0, 0);
    playSel = 0;
    checkSelections();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expQ.push_back('{1'b0, i});
      step(0, 0, 0, 0, 0, 1);
    end
    step(1, 1, 1, 1, 1, 1);
    clearModel();
    check("playing after reset button", int'(playing), 0);
    checkSelections();
    doPlay(2);

`ifdef RECORDER_CTRL_LOOP_EN
    doRecord(3);
    doPlay(7);
`endif

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0:       doSelect($urandom_range(1, 4));
        1:       doRecord($urandom_range(1, CLIP_DEPTH));
        default: doPlay($urandom_range(1, lens[playSel] + 3));
      endcase
      checkSelections();
    end

    // Asynchronous reset in the middle of a recording, with a tick in flight.
    step(0, 1, 0, 0, 0, 0);
    lens[recSel] = 0;
    for (int i = 0; i < 2; i++) begin
      expQ.push_back('{1'b1, recSel * CLIP_DEPTH + i});
      step(0, 0, 0, 0, 0, 1);
    end
    idle(2);
    sampleTick = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async reset memAddr", int'(memAddr), 0);
    check("async reset memWe", int'(memWe), 0);
    check("async reset recording", int'(recording), 0);
    check("async reset playing", int'(playing), 0);
    check("async reset recordClip", int'(recordClip), 0);
    @(posedge clock); #1 sampleTick = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    clearModel();
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    check("PlaySync after reset", int'(playing), 0);

    idle(3);
    check("scoreboard drained", expQ.size(), 0);
    check("clipFull total", clipFullSeen, clipFullExp);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/recorder_controller.md
RECORDER_CONTROLLER -- requirements
Module: recorder_controller

Interface
REQ-001 Parameter NUM_CLIPS, default 4, number of clip slots; SHALL be a power of two, 2 or more.
REQ-002 Parameter CLIP_DEPTH, default 8192, samples per clip slot; SHALL be a power of two.
REQ-003 clock  input  1  the single clock; reset is asynchronous and active-high.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 PlaySync, RecordSync, ClipNumPlaySync, ClipNumRecordSync, resetButtonSync  input  1 each  single-cycle synchronized button pulses.
REQ-006 sampleTick  input  1  one-cycle sample-rate strobe.
REQ-007 memAddr  output  log2(NUM_CLIPS)+log2(CLIP_DEPTH)  sample address = {clip, offset}.
REQ-008 memWe, memRe  output  1 each  one-cycle write and read strobes.
REQ-009 playClip, recordClip  output  log2(NUM_CLIPS) each  selected clip slots.
REQ-010 recording, playing  output  1 each  state indicators.
REQ-011 clipFull  output  1  one-cycle pulse when a recording reaches CLIP_DEPTH.

Function
REQ-012 The FSM SHALL have the states IDLE, RECORD and PLAY.
REQ-013 In IDLE, a RecordSync pulse SHALL enter RECORD, clear the offset to 0 and clear length[recordClip] to 0.
REQ-014 In IDLE, a PlaySync pulse SHALL enter PLAY at offset 0 only if length[playClip] is not 0; otherwise the pulse SHALL be ignored.
REQ-015 If PlaySync and RecordSync arrive in the same IDLE cycle, RECORD SHALL win.
REQ-016 In RECORD, each sampleTick SHALL cause memWe=1 for the following cycle, with memAddr={recordClip, offset}; offset and length SHALL increment at that same edge.
REQ-017 In RECORD, a RecordSync pulse SHALL return the FSM to IDLE and keep the length; a PlaySync pulse SHALL be ignored.
REQ-018 In RECORD, when length reaches CLIP_DEPTH the FSM SHALL return to IDLE and pulse clipFull for one cycle; offset SHALL never wrap inside a recording.
REQ-019 In PLAY, each sampleTick SHALL cause memRe=1 for the following cycle, with memAddr={playClip, offset}, and offset SHALL increment.
REQ-020 In PLAY, once the read at offset length-1 has been issued, the FSM SHALL return to IDLE; a PlaySync pulse SHALL stop playback immediately; a RecordSync pulse SHALL be ignored.
REQ-021 ClipNumPlaySync and ClipNumRecordSync SHALL increment their selection modulo NUM_CLIPS (NUM_CLIPS-1 wraps to 0), only in IDLE; in other states they SHALL be ignored.
REQ-022 A resetButtonSync pulse in any state SHALL force IDLE, clear every length and clear both selections to 0 on the next edge, and SHALL take priority over all other pulses.
REQ-023 memWe and memRe SHALL never both be 1, and SHALL be 0 whenever the state is IDLE.
REQ-024 recording and playing SHALL be registered decodes of the state.

Reset
REQ-025 On reset: state IDLE; offset 0; all lengths 0; playClip and recordClip 0; memAddr, memWe, memRe, recording, playing and clipFull all 0.
REQ-026 Reset asserted mid-operation SHALL abort the operation immediately, without issuing a further memory strobe.

Configuration
REQ-027 With RECORDER_CTRL_LOOP_EN defined, PLAY SHALL wrap offset to 0 after length-1 and continue until a PlaySync or resetButtonSync pulse.
REQ-028 Without RECORDER_CTRL_LOOP_EN, playback SHALL be single-shot per REQ-020.

Structure
REQ-029 Package recorder_pkg SHALL hold the state enum (IDLE, RECORD, PLAY), the NUM_CLIPS and CLIP_DEPTH defaults, and the derived widths.
REQ-030 Sub-module clip_length_table SHALL hold the per-clip length registers, with a write/clear-one/clear-all port and a read port for the selected play clip.

Verification (NUM_CLIPS=4, CLIP_DEPTH=16)
REQ-031 Record clip 0:
- Stimulus: RecordSync, then 5 sampleTicks, then RecordSync.
- Response: 5 memWe strobes at addresses 0..4; length[0]=5; return to IDLE.
REQ-032 Play clip 0:
- Stimulus: PlaySync, then 6 sampleTicks.
- Response: memRe at addresses 0..4; playing drops after the 5th read; the 6th tick produces no strobe.
REQ-033 Selection and full clip:
- Stimulus: ClipNumRecordSync ×5 -> recordClip=1; then record 16 ticks.
- Response: addresses 16..31; clipFull pulses once; IDLE.
REQ-034 Simultaneous pulses:
- Stimulus: PlaySync and RecordSync in the same IDLE cycle.
- Response: RECORD.
- Stimulus: PlaySync on an empty clip.
- Response: stays IDLE with no strobes.
REQ-035 Mid-operation abort:
- Stimulus: resetButtonSync during PLAY at offset 3.
- Response: IDLE next cycle; all lengths 0; a following PlaySync is ignored.
- Stimulus: async reset mid-RECORD.
- Response: all outputs 0 immediately.
REQ-036 With RECORDER_CTRL_LOOP_EN defined:
- Stimulus: play a clip of length 3 for 7 ticks.
- Response: read addresses 0,1,2,0,1,2,0.
